// File: rtl/cpu_test_harness_pkg.sv
// Shared constants for the FRANK6000 test sequencer: FSM encoding and status
// bit positions kept stable for a future register-map wrapper.
package cpu_test_harness_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] ST_LOAD = 3'd1;
  localparam logic [STATE_W-1:0] ST_CRST = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE = 3'd4;

  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_PASS_BIT    = 2;
  localparam int STAT_TIMEOUT_BIT = 3;

  // A new session may only be launched from a quiescent state.
  function automatic logic can_launch(input logic [STATE_W-1:0] st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage

// File: rtl/cpu_test_harness_if.sv
// Program-word stream into the harness: valid/data from the source, ready back.
interface cpu_test_harness_if #(
  parameter int INSTR_W = 16
);
  logic               prog_valid;
  logic [INSTR_W-1:0] prog_data;
  logic               prog_ready;

  modport master (output prog_valid, output prog_data, input prog_ready);
  modport slave  (input prog_valid, input prog_data, output prog_ready);
endinterface

// File: rtl/cpu_prog_loader.sv
// Streams program words into the CPU instruction memory write port, one
// registered write per accepted word, and flags acceptance of the last word.
module cpu_prog_loader
  import cpu_test_harness_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W:0]     i_len,
  cpu_test_harness_if.slave   prog,
  output logic [ADDR_W-1:0]   o_instr_addr,
  output logic [INSTR_W-1:0]  o_instr,
  output logic                o_we,
  output logic                o_load_done
);

  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   last_idx;
  logic              ready_q;
  logic              accept;
  logic              last_word;

  assign accept          = prog.prog_valid & ready_q;
  // Compare one bit wider than the address so a full-depth load ends at the
  // top address instead of wrapping round for a second pass.
  assign last_word       = ({1'b0, addr_cnt} == last_idx);
  assign o_load_done     = accept & last_word;
  assign prog.prog_ready = ready_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ready_q      <= 1'b0;
      addr_cnt     <= '0;
      last_idx     <= '0;
      o_we         <= 1'b0;
      o_instr_addr <= '0;
      o_instr      <= '0;
    end else begin
      o_we <= 1'b0;
      if (i_start) begin
        ready_q  <= (i_len != '0);
        addr_cnt <= '0;
        last_idx <= i_len - 1'b1;
      end else if (accept) begin
        o_we         <= 1'b1;
        o_instr_addr <= addr_cnt;
        o_instr      <= prog.prog_data;
        addr_cnt     <= addr_cnt + 1'b1;
        if (last_word) ready_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cpu_test_harness.sv
// On-chip self-test sequencer: load program, pulse CPU reset, run until the
// loop flag rises or the cycle budget expires, then report pass/timeout.
module cpu_test_harness
  import cpu_test_harness_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int INSTR_W    = 16,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT_W  = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [ADDR_W:0]      i_prog_len,
  input  logic [TIMEOUT_W-1:0] i_timeout,
  input  logic [DATA_W-1:0]    i_expect,
  cpu_test_harness_if.slave    prog,
  output logic [ADDR_W-1:0]    o_instr_addr,
  output logic [INSTR_W-1:0]   o_instr,
  output logic                 o_we,
  output logic                 o_cpu_rst,
  output logic                 o_cpu_on,
  input  logic [DATA_W-1:0]    i_cpu_wreg,
  input  logic                 i_cpu_loopf,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic                 o_timeout,
  output logic [TIMEOUT_W-1:0] o_cycles,
  output logic [DATA_W-1:0]    o_wreg_final
);

  localparam int CRST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CRST_W-1:0] CRST_LAST = CRST_W'(RST_CYCLES - 1);

  logic [STATE_W-1:0]   state_q;
  logic [TIMEOUT_W-1:0] timeout_q;
  logic [DATA_W-1:0]    expect_q;
  logic [CRST_W-1:0]    crst_cnt;
  logic                 prev_loopf;
  logic                 launch;
  logic                 load_done;
  logic [TIMEOUT_W-1:0] cnt_next;
  logic                 loopf_rise;
  logic                 hit_timeout;

  assign launch      = i_start & can_launch(state_q);
  // Saturate so an unbounded run never wraps back to a small count.
  assign cnt_next    = (&o_cycles) ? o_cycles : o_cycles + 1'b1;
  assign loopf_rise  = i_cpu_loopf & ~prev_loopf;
  assign hit_timeout = (timeout_q != '0) && (cnt_next == timeout_q);

  cpu_prog_loader #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_loader (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_start      (launch),
    .i_len        (i_prog_len),
    .prog         (prog),
    .o_instr_addr (o_instr_addr),
    .o_instr      (o_instr),
    .o_we         (o_we),
    .o_load_done  (load_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      timeout_q    <= '0;
      expect_q     <= '0;
      crst_cnt     <= '0;
      prev_loopf   <= 1'b0;
      o_cpu_rst    <= 1'b1;
      o_cpu_on     <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_timeout    <= 1'b0;
      o_cycles     <= '0;
      o_wreg_final <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (launch) begin
            timeout_q    <= i_timeout;
            expect_q     <= i_expect;
            crst_cnt     <= '0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_timeout    <= 1'b0;
            o_cycles     <= '0;
            o_wreg_final <= '0;
            o_busy       <= 1'b1;
            o_cpu_on     <= 1'b0;
            o_cpu_rst    <= 1'b1;
            state_q      <= (i_prog_len != '0) ? ST_LOAD : ST_CRST;
          end
        end
        ST_LOAD: begin
          // The last word's write and the first reset-hold cycle coincide.
          if (load_done) begin
            crst_cnt <= '0;
            state_q  <= ST_CRST;
          end
        end
        ST_CRST: begin
          if (crst_cnt == CRST_LAST) begin
            o_cpu_rst  <= 1'b0;
            o_cpu_on   <= 1'b1;
            prev_loopf <= i_cpu_loopf;
            o_cycles   <= '0;
            state_q    <= ST_RUN;
          end else begin
            crst_cnt <= crst_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          prev_loopf <= i_cpu_loopf;
          o_cycles   <= cnt_next;
          if (loopf_rise || hit_timeout) begin
            o_wreg_final <= i_cpu_wreg;
            o_pass       <= loopf_rise && (i_cpu_wreg == expect_q);
            o_timeout    <= ~loopf_rise;
            o_done       <= 1'b1;
            o_busy       <= 1'b0;
            o_cpu_on     <= 1'b0;
            o_cpu_rst    <= 1'b0;
            state_q      <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
